sop_scan_ctrl: RTL



---
 rtl/sop_scan_pkg.sv | 20 ++
 rtl/sop_scan_cmp.sv | 86 ++++++++
 rtl/sop_scan_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sop_scan_pkg.sv
// -----------------------------------------------------------------------------
// sop_scan_pkg
// Shared definitions for the SoP/PoS truth-table scan controller.
//   - state_t       : scan FSM state encoding (IDLE / WAIT / SAMPLE)
//   - DEF_N_IN      : default function input count
//   - DEF_SETTLE    : default settle cycles between drive and sample
// No ports (package).
// -----------------------------------------------------------------------------
package sop_scan_pkg;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_SETTLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

endpackage : sop_scan_pkg

// File: rtl/sop_scan_cmp.sv
// -----------------------------------------------------------------------------
// sop_scan_cmp
// Per-sample comparison of the function output against the expected table bit.
// Keeps the saturating mismatch counter and, when SOP_SCAN_FAIL_LOG_EN is
// defined, captures the index of the first mismatch of a scan.
//
// Ports:
//   clk, rst       in   clock, asynchronous active-high reset
//   i_clear        in   start of a new scan: zero counter and fail log
//   i_sample       in   a vector is being sampled this cycle
//   i_idx          in   index of the vector being sampled
//   i_f_out        in   sampled function output
//   i_exp_bit      in   expected output for i_idx
//   o_err_count    out  number of mismatches so far (never wraps)
//   o_ff_idx       out  first mismatching index (0 when logging disabled)
//   o_ff_vld       out  a mismatch has been logged (0 when logging disabled)
//
// Configuration macro: SOP_SCAN_FAIL_LOG_EN enables first-fail capture.
// -----------------------------------------------------------------------------
module sop_scan_cmp
  import sop_scan_pkg::*;
#(
  parameter int N_IN = DEF_N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_sample,
  input  logic [N_IN-1:0] i_idx,
  input  logic            i_f_out,
  input  logic            i_exp_bit,
  output logic [N_IN:0]   o_err_count,
  output logic [N_IN-1:0] o_ff_idx,
  output logic            o_ff_vld
);

  localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

  logic          w_miss;
  logic [N_IN:0] r_err_count;

  // Case inequality so an X/Z output is treated as a mismatch.
  assign w_miss = (i_f_out !== i_exp_bit);

  // Mismatch counter; saturates at the table size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= {(N_IN+1){1'b0}};
    end else if (i_clear) begin
      r_err_count <= {(N_IN+1){1'b0}};
    end else if (i_sample && w_miss && (r_err_count != ERR_MAX)) begin
      r_err_count <= r_err_count + {{N_IN{1'b0}}, 1'b1};
    end
  end

  assign o_err_count = r_err_count;

`ifdef SOP_SCAN_FAIL_LOG_EN
  logic [N_IN-1:0] r_ff_idx;
  logic            r_ff_vld;

  // First-fail capture: only the first mismatch of a scan is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff_idx <= {N_IN{1'b0}};
      r_ff_vld <= 1'b0;
    end else if (i_clear) begin
      r_ff_idx <= {N_IN{1'b0}};
      r_ff_vld <= 1'b0;
    end else if (i_sample && w_miss && !r_ff_vld) begin
      r_ff_idx <= i_idx;
      r_ff_vld <= 1'b1;
    end
  end

  assign o_ff_idx = r_ff_idx;
  assign o_ff_vld = r_ff_vld;
`else
  logic w_unused_idx;

  assign w_unused_idx = ^i_idx;
  assign o_ff_idx     = {N_IN{1'b0}};
  assign o_ff_vld     = 1'b0;
`endif

endmodule : sop_scan_cmp

// File: rtl/sop_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sop_scan_ctrl
// Drives a combinational function through all 2^N_IN input vectors, samples
// its output SETTLE cycles after each drive, and compares the collected truth
// table with an expected minterm mask.
//
// Ports:
//   clk, rst        in   clock, asynchronous active-high reset
//   start           in   begin a scan (accepted only while idle)
//   abort           in   cancel a scan; no done pulse (wins over start)
//   expected        in   expected table, bit i = f(i); latched on start
//   f_in            out  vector driven to the function (MSB = a)
//   f_out           in   function output
//   busy            out  scan in progress
//   done            out  one-cycle pulse at scan completion
//   result_mask     out  sampled table, bit i = f_out for vector i
//   pass            out  result_mask equals latched expected
//   err_count       out  number of mismatching bits
//   first_fail_idx  out  lowest mismatching index
//   first_fail_vld  out  a mismatch was recorded
//
// Configuration macro: SOP_SCAN_FAIL_LOG_EN enables first-fail capture;
// when undefined first_fail_idx/first_fail_vld are tied to 0.
// -----------------------------------------------------------------------------
module sop_scan_ctrl
  import sop_scan_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [(1<<N_IN)-1:0] expected,
  output logic [N_IN-1:0]      f_in,
  input  logic                 f_out,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] result_mask,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 first_fail_vld
);

  localparam int              TBL      = 1 << N_IN;
  localparam int              CW       = $clog2(SETTLE + 2);
  localparam logic [CW-1:0]   CNT_LAST = (SETTLE > 0) ? CW'(SETTLE - 1) : {CW{1'b0}};
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
  // With no settle time every vector goes straight to sampling.
  localparam state_t          VEC_ST   = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_idx;
  logic [TBL-1:0]  r_exp;
  logic [TBL-1:0]  r_mask;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [TBL-1:0]  w_mask_next;
  logic            w_start_acc;
  logic            w_sample;

  assign w_start_acc = (r_state == ST_IDLE) && start && !abort;
  assign w_sample    = (r_state == ST_SAMPLE) && !abort;

  // Table including the bit being sampled this cycle, so pass sees the final mask.
  always_comb begin
    w_mask_next        = r_mask;
    w_mask_next[r_idx] = f_out;
  end

  // Scan FSM: vector index, settle counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_idx   <= {N_IN{1'b0}};
      r_exp   <= {TBL{1'b0}};
      r_mask  <= {TBL{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_acc) begin
            r_exp   <= expected;
            r_idx   <= {N_IN{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_mask  <= {TBL{1'b0}};
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= VEC_ST;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_mask <= w_mask_next;
            if (r_idx == IDX_LAST) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_mask_next === r_exp);
            end else begin
              r_idx   <= r_idx + {{(N_IN-1){1'b0}}, 1'b1};
              r_cnt   <= {CW{1'b0}};
              r_state <= VEC_ST;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sop_scan_cmp #(
    .N_IN (N_IN)
  ) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_acc),
    .i_sample    (w_sample),
    .i_idx       (r_idx),
    .i_f_out     (f_out),
    .i_exp_bit   (r_exp[r_idx]),
    .o_err_count (err_count),
    .o_ff_idx    (first_fail_idx),
    .o_ff_vld    (first_fail_vld)
  );

  assign f_in        = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign result_mask = r_mask;
  assign pass        = r_pass;

endmodule : sop_scan_ctrl
